// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, exception cause codes
// and the fixed control-output patterns the FSM selects between.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        EXC_NONE     = 3'd0,
        EXC_INST_MEM = 3'd1,
        EXC_REG_FILE = 3'd2,
        EXC_ALU      = 3'd3,
        EXC_DATA_MEM = 3'd4
    } exc_cause_e;

    typedef struct packed {
        logic pc_write;
        logic if_write;
        logic if_flush;
        logic ex_bubble;
        logic halted;
    } ctrl_t;

    //                                      pcw   ifw   iff   bub   hlt
    localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_DRAIN  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_HALTED = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Highest-priority source wins when several exceptions fire together.
    function automatic exc_cause_e exc_encode(input logic inst_mem, input logic reg_file,
                                              input logic alu, input logic data_mem);
        if (inst_mem)      return EXC_INST_MEM;
        else if (reg_file) return EXC_REG_FILE;
        else if (alu)      return EXC_ALU;
        else if (data_mem) return EXC_DATA_MEM;
        else               return EXC_NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare: the EX-stage load targets a register that the
// decode-stage instruction reads. Purely combinational.
module load_use_detect #(
    parameter int REG_NUM_WIDTH = 4
) (
    input  logic [REG_NUM_WIDTH-1:0] i_rn_1_dec,
    input  logic [REG_NUM_WIDTH-1:0] i_rn_2_dec,
    input  logic                     i_uses_rn2_dec,
    input  logic [REG_NUM_WIDTH-1:0] i_rn1_ex,
    input  logic                     i_write_reg_ex,
    input  logic                     i_mem_read_ex,
    output logic                     o_hazard
);

    logic w_match_1;
    logic w_match_2;

    assign w_match_1 = (i_rn1_ex == i_rn_1_dec);
    assign w_match_2 = i_uses_rn2_dec & (i_rn1_ex == i_rn_2_dec);
    assign o_hazard  = i_mem_read_ex & i_write_reg_ex & (w_match_1 | w_match_2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/jump flushes, halt and exception
// drain, first-exception capture and saturating stall/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = 16,
    parameter int REG_NUM_WIDTH   = 4,
    parameter int STALL_CYCLES    = 1,
    parameter int DRAIN_CYCLES    = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_NUM_WIDTH-1:0]   rn_1_dec,
    input  logic [REG_NUM_WIDTH-1:0]   rn_2_dec,
    input  logic                       uses_rn2_dec,
    input  logic [REG_NUM_WIDTH-1:0]   rn1_ex,
    input  logic                       write_reg_ex,
    input  logic                       mem_read_ex,
    input  logic                       branch_dec,
    input  logic                       jump_dec,
    input  logic                       halt_dec,
    input  logic                       exc_inst_mem,
    input  logic                       exc_reg_file,
    input  logic                       exc_alu,
    input  logic                       exc_data_mem,
    input  logic [INST_ADDR_WIDTH-1:0] pc_decode,
    input  logic                       resume,
    output logic                       pc_write,
    output logic                       if_write,
    output logic                       if_flush,
    output logic                       ex_bubble,
    output logic                       halted,
    output logic                       exc_valid,
    output logic [2:0]                 exc_cause,
    output logic [INST_ADDR_WIDTH-1:0] exc_pc,
    output logic                       exc_multi,
    output logic [CNT_WIDTH-1:0]       stall_cnt,
    output logic [CNT_WIDTH-1:0]       flush_cnt
);

    localparam int DOWN_MAX = (STALL_CYCLES > DRAIN_CYCLES) ? STALL_CYCLES : DRAIN_CYCLES;
    localparam int DW       = (DOWN_MAX > 1) ? $clog2(DOWN_MAX) : 1;
    localparam logic [DW-1:0] STALL_LOAD = DW'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_e                     r_state;
    state_e                     w_next_state;
    logic [DW-1:0]              r_cnt;
    logic [DW-1:0]              w_next_cnt;
    ctrl_t                      w_ctrl;
    logic                       w_hazard;
    logic                       w_exc_any;
    exc_cause_e                 w_exc_code;
    logic                       w_stall_inc;
    logic                       w_flush_inc;
    logic                       w_capture;
    logic                       w_multi_set;
    logic                       w_resume_clear;

    logic                       r_exc_valid;
    exc_cause_e                 r_exc_cause;
    logic [INST_ADDR_WIDTH-1:0] r_exc_pc;
    logic                       r_exc_multi;
    logic [CNT_WIDTH-1:0]       r_stall_cnt;
    logic [CNT_WIDTH-1:0]       r_flush_cnt;

    load_use_detect #(
        .REG_NUM_WIDTH (REG_NUM_WIDTH)
    ) u_load_use_detect (
        .i_rn_1_dec     (rn_1_dec),
        .i_rn_2_dec     (rn_2_dec),
        .i_uses_rn2_dec (uses_rn2_dec),
        .i_rn1_ex       (rn1_ex),
        .i_write_reg_ex (write_reg_ex),
        .i_mem_read_ex  (mem_read_ex),
        .o_hazard       (w_hazard)
    );

    assign w_exc_any  = exc_inst_mem | exc_reg_file | exc_alu | exc_data_mem;
    assign w_exc_code = exc_encode(exc_inst_mem, exc_reg_file, exc_alu, exc_data_mem);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_ctrl         = CTRL_RUN;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        w_capture      = 1'b0;
        w_multi_set    = 1'b0;
        w_resume_clear = 1'b0;

        case (r_state)
            ST_RUN, ST_STALL: begin
                if (w_exc_any) begin
                    w_ctrl       = CTRL_DRAIN;
                    w_capture    = 1'b1;
                    w_next_state = ST_DRAIN;
                    w_next_cnt   = DRAIN_LOAD;
                end else if (r_state == ST_STALL) begin
                    // Decode stays frozen; branch/halt are re-evaluated back in RUN.
                    w_ctrl      = CTRL_STALL;
                    w_stall_inc = 1'b1;
                    if (r_cnt == '0) w_next_state = ST_RUN;
                    else             w_next_cnt   = r_cnt - 1'b1;
                end else if (halt_dec) begin
                    w_ctrl       = CTRL_DRAIN;
                    w_next_state = ST_DRAIN;
                    w_next_cnt   = DRAIN_LOAD;
                end else if (w_hazard) begin
                    w_ctrl      = CTRL_STALL;
                    w_stall_inc = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        w_next_state = ST_STALL;
                        w_next_cnt   = STALL_LOAD;
                    end
                end else if (branch_dec | jump_dec) begin
                    w_ctrl      = CTRL_FLUSH;
                    w_flush_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_ctrl      = CTRL_DRAIN;
                w_multi_set = w_exc_any;
                if (r_cnt == '0) w_next_state = ST_HALTED;
                else             w_next_cnt   = r_cnt - 1'b1;
            end
            ST_HALTED: begin
                w_ctrl = CTRL_HALTED;
                if (resume) begin
                    w_next_state   = ST_RUN;
                    w_resume_clear = 1'b1;
                end
            end
            default: w_next_state = ST_RUN;
        endcase

        if (rst) w_ctrl = CTRL_RESET;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= EXC_NONE;
            r_exc_pc    <= '0;
            r_exc_multi <= 1'b0;
        end else begin
            if (w_capture) begin
                r_exc_valid <= 1'b1;
                r_exc_cause <= w_exc_code;
                r_exc_pc    <= pc_decode;
            end
            if (w_multi_set) r_exc_multi <= 1'b1;
            // exc_pc survives resume so software can still inspect it.
            if (w_resume_clear) begin
                r_exc_valid <= 1'b0;
                r_exc_cause <= EXC_NONE;
                r_exc_multi <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign pc_write  = w_ctrl.pc_write;
    assign if_write  = w_ctrl.if_write;
    assign if_flush  = w_ctrl.if_flush;
    assign ex_bubble = w_ctrl.ex_bubble;
    assign halted    = w_ctrl.halted;
    assign exc_valid = r_exc_valid;
    assign exc_cause = r_exc_cause;
    assign exc_pc    = r_exc_pc;
    assign exc_multi = r_exc_multi;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a behavioural model checked every cycle on the falling
// edge, plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_ctrl;

    localparam int AW        = 16;
    localparam int RW        = 4;
    localparam int STALL_N   = 2;
    localparam int DRAIN_N   = 2;
    localparam int CW        = 16;
    localparam int CW_SAT    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rn_1_dec, rn_2_dec, rn1_ex;
    logic          uses_rn2_dec, write_reg_ex, mem_read_ex;
    logic          branch_dec, jump_dec, halt_dec;
    logic          exc_inst_mem, exc_reg_file, exc_alu, exc_data_mem;
    logic [AW-1:0] pc_decode;
    logic          resume;

    logic          pc_write, if_write, if_flush, ex_bubble, halted;
    logic          exc_valid, exc_multi;
    logic [2:0]    exc_cause;
    logic [AW-1:0] exc_pc;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic              s_pc_write, s_if_write, s_if_flush, s_ex_bubble, s_halted;
    logic              s_exc_valid, s_exc_multi;
    logic [2:0]        s_exc_cause;
    logic [AW-1:0]     s_exc_pc;
    logic [CW_SAT-1:0] s_stall_cnt, s_flush_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .INST_ADDR_WIDTH (AW), .REG_NUM_WIDTH (RW), .STALL_CYCLES (STALL_N),
        .DRAIN_CYCLES (DRAIN_N), .CNT_WIDTH (CW)
    ) dut (
        .clk (clk), .rst (rst),
        .rn_1_dec (rn_1_dec), .rn_2_dec (rn_2_dec), .uses_rn2_dec (uses_rn2_dec),
        .rn1_ex (rn1_ex), .write_reg_ex (write_reg_ex), .mem_read_ex (mem_read_ex),
        .branch_dec (branch_dec), .jump_dec (jump_dec), .halt_dec (halt_dec),
        .exc_inst_mem (exc_inst_mem), .exc_reg_file (exc_reg_file),
        .exc_alu (exc_alu), .exc_data_mem (exc_data_mem),
        .pc_decode (pc_decode), .resume (resume),
        .pc_write (pc_write), .if_write (if_write), .if_flush (if_flush),
        .ex_bubble (ex_bubble), .halted (halted),
        .exc_valid (exc_valid), .exc_cause (exc_cause), .exc_pc (exc_pc),
        .exc_multi (exc_multi), .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
    );

    // Narrow-counter twin driven by the same stimulus, so saturation is reached quickly.
    pipeline_ctrl #(
        .INST_ADDR_WIDTH (AW), .REG_NUM_WIDTH (RW), .STALL_CYCLES (STALL_N),
        .DRAIN_CYCLES (DRAIN_N), .CNT_WIDTH (CW_SAT)
    ) dut_sat (
        .clk (clk), .rst (rst),
        .rn_1_dec (rn_1_dec), .rn_2_dec (rn_2_dec), .uses_rn2_dec (uses_rn2_dec),
        .rn1_ex (rn1_ex), .write_reg_ex (write_reg_ex), .mem_read_ex (mem_read_ex),
        .branch_dec (branch_dec), .jump_dec (jump_dec), .halt_dec (halt_dec),
        .exc_inst_mem (exc_inst_mem), .exc_reg_file (exc_reg_file),
        .exc_alu (exc_alu), .exc_data_mem (exc_data_mem),
        .pc_decode (pc_decode), .resume (resume),
        .pc_write (s_pc_write), .if_write (s_if_write), .if_flush (s_if_flush),
        .ex_bubble (s_ex_bubble), .halted (s_halted),
        .exc_valid (s_exc_valid), .exc_cause (s_exc_cause), .exc_pc (s_exc_pc),
        .exc_multi (s_exc_multi), .stall_cnt (s_stall_cnt), .flush_cnt (s_flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_halted     = 1'b0;
    int       m_stall_left = 0;    // extra forced stall cycles still owed
    int       m_drain_left = -1;   // -1 when not draining
    bit       m_exc_valid  = 1'b0;
    int       m_cause      = 0;
    bit [15:0] m_pc        = '0;
    bit       m_multi      = 1'b0;
    int       m_stalls     = 0;
    int       m_flushes    = 0;

    function automatic bit m_hazard();
        return mem_read_ex && write_reg_ex &&
               (rn1_ex == rn_1_dec || (uses_rn2_dec && rn1_ex == rn_2_dec));
    endfunction

    function automatic bit m_exc_any();
        return exc_inst_mem || exc_reg_file || exc_alu || exc_data_mem;
    endfunction

    function automatic int m_first_cause();
        if (exc_inst_mem) return 1;
        if (exc_reg_file) return 2;
        if (exc_alu)      return 3;
        if (exc_data_mem) return 4;
        return 0;
    endfunction

    // {pc_write, if_write, if_flush, ex_bubble, halted}
    function automatic logic [4:0] m_ctrl();
        if (rst)                                 return 5'b00110;
        if (m_halted)                            return 5'b00011;
        if (m_drain_left >= 0 || m_exc_any())    return 5'b00110;
        if (m_stall_left > 0)                    return 5'b00010;
        if (halt_dec)                            return 5'b00110;
        if (m_hazard())                          return 5'b00010;
        if (branch_dec || jump_dec)              return 5'b10100;
        return 5'b11000;
    endfunction

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_halted <= 1'b0; m_stall_left <= 0; m_drain_left <= -1;
            m_exc_valid <= 1'b0; m_cause <= 0; m_pc <= '0; m_multi <= 1'b0;
            m_stalls <= 0; m_flushes <= 0;
        end else if (m_halted) begin
            if (resume) begin
                m_halted <= 1'b0; m_exc_valid <= 1'b0; m_cause <= 0; m_multi <= 1'b0;
            end
        end else if (m_drain_left >= 0) begin
            if (m_exc_any()) m_multi <= 1'b1;
            if (m_drain_left == 0) begin
                m_drain_left <= -1;
                m_halted     <= 1'b1;
            end else begin
                m_drain_left <= m_drain_left - 1;
            end
        end else if (m_exc_any()) begin
            m_exc_valid  <= 1'b1;
            m_cause      <= m_first_cause();
            m_pc         <= pc_decode;
            m_drain_left <= DRAIN_N - 1;
            m_stall_left <= 0;
        end else if (m_stall_left > 0) begin
            m_stalls     <= m_stalls + 1;
            m_stall_left <= m_stall_left - 1;
        end else if (halt_dec) begin
            m_drain_left <= DRAIN_N - 1;
        end else if (m_hazard()) begin
            m_stalls     <= m_stalls + 1;
            m_stall_left <= STALL_N - 1;
        end else if (branch_dec || jump_dec) begin
            m_flushes    <= m_flushes + 1;
        end
    end

    always @(negedge clk) begin
        logic [4:0] exp_ctrl;
        exp_ctrl = m_ctrl();
        check("ctrl", 32'({pc_write, if_write, if_flush, ex_bubble, halted}), 32'(exp_ctrl));
        check("exc_valid", 32'(exc_valid), 32'(m_exc_valid));
        check("exc_cause", 32'(exc_cause), 32'(m_cause));
        check("exc_pc", 32'(exc_pc), 32'(m_pc));
        check("exc_multi", 32'(exc_multi), 32'(m_multi));
        check("stall_cnt", 32'(stall_cnt), 32'(sat(m_stalls, CW)));
        check("flush_cnt", 32'(flush_cnt), 32'(sat(m_flushes, CW)));
        check("sat.ctrl", 32'({s_pc_write, s_if_write, s_if_flush, s_ex_bubble, s_halted}),
              32'(exp_ctrl));
        check("sat.exc", 32'({s_exc_valid, s_exc_cause, s_exc_multi}),
              32'({m_exc_valid, 3'(m_cause), m_multi}));
        check("sat.exc_pc", 32'(s_exc_pc), 32'(m_pc));
        check("sat.stall_cnt", 32'(s_stall_cnt), 32'(sat(m_stalls, CW_SAT)));
        check("sat.flush_cnt", 32'(s_flush_cnt), 32'(sat(m_flushes, CW_SAT)));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rn_1_dec = '0; rn_2_dec = '0; uses_rn2_dec = 1'b0; rn1_ex = '0;
        write_reg_ex = 1'b0; mem_read_ex = 1'b0;
        branch_dec = 1'b0; jump_dec = 1'b0; halt_dec = 1'b0;
        exc_inst_mem = 1'b0; exc_reg_file = 1'b0; exc_alu = 1'b0; exc_data_mem = 1'b0;
        resume = 1'b0;
    endtask

    task automatic set_load_use(input logic [RW-1:0] dst, input logic [RW-1:0] src1,
                                input logic [RW-1:0] src2, input logic use2);
        mem_read_ex = 1'b1; write_reg_ex = 1'b1; rn1_ex = dst;
        rn_1_dec = src1; rn_2_dec = src2; uses_rn2_dec = use2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pc_decode = '0;
        clear_inputs();
        tick(); tick();
        check("rst.ctrl", 32'({pc_write, if_write, if_flush, ex_bubble, halted}), 32'h06);
        rst = 1'b0;
        #1;
        check("run.pc_write", 32'(pc_write), 32'd1);
        check("run.if_write", 32'(if_write), 32'd1);
        check("run.stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use on rn_1: two bubble cycles.
        set_load_use(4'd3, 4'd3, 4'd0, 1'b0);
        #1;
        check("lu1.pc_write", 32'(pc_write), 32'd0);
        check("lu1.ex_bubble", 32'(ex_bubble), 32'd1);
        tick(); clear_inputs(); #1;
        check("lu1b.pc_write", 32'(pc_write), 32'd0);
        check("lu1b.ex_bubble", 32'(ex_bubble), 32'd1);
        tick();
        check("lu1.done_pc_write", 32'(pc_write), 32'd1);
        check("lu1.stall_cnt", 32'(stall_cnt), 32'd2);

        // rn_2 matches but is unused, or the EX op writes nothing: no hazard.
        set_load_use(4'd3, 4'd0, 4'd3, 1'b0);
        #1;
        check("nolu.rn2_unused", 32'(pc_write), 32'd1);
        write_reg_ex = 1'b0; uses_rn2_dec = 1'b1;
        #1;
        check("nolu.no_write", 32'(pc_write), 32'd1);
        tick();
        set_load_use(4'd3, 4'd0, 4'd3, 1'b1);
        #1;
        check("lu2.pc_write", 32'(pc_write), 32'd0);
        tick(); clear_inputs(); tick();

        // Branch arriving together with a hazard waits out the stall.
        set_load_use(4'd5, 4'd5, 4'd0, 1'b0);
        branch_dec = 1'b1;
        #1;
        check("br_lu.if_flush", 32'(if_flush), 32'd0);
        tick();
        mem_read_ex = 1'b0; write_reg_ex = 1'b0;
        #1;
        check("br_stall.if_flush", 32'(if_flush), 32'd0);
        tick();
        check("br.if_flush", 32'(if_flush), 32'd1);
        check("br.flush_cnt_before", 32'(flush_cnt), 32'd0);
        tick();
        branch_dec = 1'b0;
        #1;
        check("br.flush_cnt", 32'(flush_cnt), 32'd1);

        // Three jumps: wide counter reaches 4, 2-bit twin sticks at 3.
        jump_dec = 1'b1;
        tick(); tick(); tick();
        jump_dec = 1'b0;
        #1;
        check("jmp.flush_cnt", 32'(flush_cnt), 32'd4);
        check("jmp.sat_flush_cnt", 32'(s_flush_cnt), 32'd3);
        check("sat.stall_cnt_lit", 32'(s_stall_cnt), 32'd3);
        check("wide.stall_cnt_lit", 32'(stall_cnt), 32'd6);

        // resume outside HALTED is ignored.
        resume = 1'b1;
        tick();
        resume = 1'b0;

        // ALU + data-mem exception together: ALU wins, then a further exception in DRAIN.
        pc_decode = 16'h0040; exc_alu = 1'b1; exc_data_mem = 1'b1;
        #1;
        check("exc.pc_write", 32'(pc_write), 32'd0);
        check("exc.if_flush", 32'(if_flush), 32'd1);
        tick();
        exc_alu = 1'b0; exc_data_mem = 1'b0; exc_inst_mem = 1'b1; pc_decode = 16'h0050;
        #1;
        check("exc.cause", 32'(exc_cause), 32'd3);
        check("exc.pc", 32'(exc_pc), 32'h0040);
        check("exc.valid", 32'(exc_valid), 32'd1);
        check("drain1.halted", 32'(halted), 32'd0);
        tick();
        exc_inst_mem = 1'b0;
        #1;
        check("exc.multi", 32'(exc_multi), 32'd1);
        check("exc.cause_kept", 32'(exc_cause), 32'd3);
        check("drain2.halted", 32'(halted), 32'd0);
        tick();
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.ctrl", 32'({pc_write, if_write, if_flush, ex_bubble}), 32'h1);
        tick();
        resume = 1'b1;
        #1;
        check("resume.still_halted", 32'(halted), 32'd1);
        tick();
        resume = 1'b0;
        #1;
        check("resume.halted", 32'(halted), 32'd0);
        check("resume.exc_valid", 32'(exc_valid), 32'd0);
        check("resume.exc_cause", 32'(exc_cause), 32'd0);
        check("resume.exc_multi", 32'(exc_multi), 32'd0);
        check("resume.exc_pc", 32'(exc_pc), 32'h0040);
        check("resume.pc_write", 32'(pc_write), 32'd1);

        // Halt opcode drains to HALTED without an exception.
        halt_dec = 1'b1;
        #1;
        check("hlt.if_flush", 32'(if_flush), 32'd1);
        tick();
        halt_dec = 1'b0;
        tick(); tick();
        check("hlt.halted", 32'(halted), 32'd1);
        check("hlt.exc_valid", 32'(exc_valid), 32'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;

        // Exception during STALL, then asynchronous reset in the middle of DRAIN.
        set_load_use(4'd7, 4'd7, 4'd0, 1'b0);
        tick();
        clear_inputs();
        exc_reg_file = 1'b1; pc_decode = 16'h0123;
        #1;
        check("stall_exc.ctrl", 32'({pc_write, if_flush, ex_bubble}), 32'h3);
        tick();
        exc_reg_file = 1'b0;
        #1;
        check("stall_exc.cause", 32'(exc_cause), 32'd2);
        check("stall_exc.pc", 32'(exc_pc), 32'h0123);
        check("stall_exc.stall_cnt", 32'(stall_cnt), 32'd7);
        #1;
        rst = 1'b1;
        #1;
        check("arst.ctrl", 32'({pc_write, if_write, if_flush, ex_bubble, halted}), 32'h06);
        check("arst.exc", 32'({exc_valid, exc_cause, exc_multi}), 32'd0);
        check("arst.exc_pc", 32'(exc_pc), 32'd0);
        check("arst.counters", 32'({stall_cnt, flush_cnt}), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("arst.run", 32'(pc_write), 32'd1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
